// File: rtl/imem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_line_responder                                           |
// | Purpose  : Direct-mapped, read-only instruction cache with 32-byte lines |
// |            answering the fetch stage's imem port. Misses are filled from |
// |            a 64-bit burst memory port, four beats per line.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst      : clock, synchronous active-high reset                   |
// |   imem_addr     : request address (bits [1:0] ignored)                   |
// |   imem_rmask    : request valid when nonzero; full word always returned  |
// |   imem_rdata    : instruction word, valid while imem_resp=1              |
// |   imem_resp     : one-cycle response strobe                              |
// |   bmem_addr     : line-aligned burst address                             |
// |   bmem_read     : burst read request, held until bmem_ready              |
// |   bmem_ready    : burst request accepted this cycle                      |
// |   bmem_rdata    : burst beat data                                        |
// |   bmem_rvalid   : burst beat valid, beat 0 first                         |
// +--------------------------------------------------------------------------+
module imem_line_responder #(
  parameter int NUM_SETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 32 - 5 - IW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPARE = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  logic [2:0]          state_q,     state_d;
  logic [31:2]         addr_q,      addr_d;
  logic [31:0]         bmem_addr_q, bmem_addr_d;
  logic [1:0]          beat_q,      beat_d;
  logic [255:0]        fill_q,      fill_d;
  logic [31:0]         rdata_q,     rdata_d;
  logic [NUM_SETS-1:0] valid_q,     valid_d;

  // Line storage; only the valid bits need a reset value.
  logic [TW-1:0]       tag_mem  [NUM_SETS];
  logic [255:0]        line_mem [NUM_SETS];

  logic [TW-1:0]  w_tag;
  logic [IW-1:0]  w_index;
  logic [2:0]     w_word;
  logic           w_hit;
  logic           w_line_write;
  logic [255:0]   w_line_wdata;
  logic           w_resp;
  logic [31:0]    w_word_data;
  logic           w_accept_ok;

  // Byte offset within a word is never used: any nonzero mask returns the word.
  logic w_unused;
  assign w_unused = &{1'b0, imem_addr[1:0]};

  assign w_tag   = addr_q[31:5+IW];
  assign w_index = addr_q[5+IW-1:5];
  assign w_word  = addr_q[4:2];

  assign w_hit = valid_q[w_index] && (tag_mem[w_index] == w_tag);

  // The final beat is merged directly so the array and the fill buffer are
  // complete on the same edge.
  assign w_line_write = (state_q == S_FILL) && bmem_rvalid && (beat_q == 2'd3);
  assign w_line_wdata = {bmem_rdata, fill_q[191:0]};

  assign w_resp = ((state_q == S_COMPARE) && w_hit) || (state_q == S_RESPOND);

  // RESPOND serves from the fill buffer so it does not depend on array timing.
  assign w_word_data = (state_q == S_RESPOND) ? fill_q[{w_word, 5'b0} +: 32]
                                              : line_mem[w_index][{w_word, 5'b0} +: 32];

  // New requests are only latched when the previous one is finished.
  assign w_accept_ok = (state_q == S_IDLE) || w_resp;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bmem_addr_d = bmem_addr_q;
    beat_d      = beat_q;
    fill_d      = fill_q;
    valid_d     = valid_q;
    rdata_d     = w_resp ? w_word_data : rdata_q;

    case (state_q)
      S_IDLE, S_RESPOND: begin
        state_d = S_IDLE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_REQ;
          bmem_addr_d = {addr_q[31:5], 5'b0};
        end
      end
      S_REQ: begin
        if (bmem_ready) begin
          state_d = S_FILL;
          beat_d  = 2'd0;
        end
      end
      S_FILL: begin
        if (bmem_rvalid) begin
          fill_d[{beat_q, 6'b0} +: 64] = bmem_rdata;
          beat_d                       = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            valid_d[w_index] = 1'b1;
            state_d          = S_RESPOND;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_accept_ok && (imem_rmask != 4'h0)) begin
      addr_d  = imem_addr[31:2];
      state_d = S_COMPARE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bmem_addr_q <= '0;
      beat_q      <= '0;
      fill_q      <= '0;
      rdata_q     <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bmem_addr_q <= bmem_addr_d;
      beat_q      <= beat_d;
      fill_q      <= fill_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_line_write) begin
      line_mem[w_index] <= w_line_wdata;
      tag_mem[w_index]  <= w_tag;
    end
  end

  assign imem_resp  = w_resp;
  assign imem_rdata = w_resp ? w_word_data : rdata_q;
  assign bmem_read  = (state_q == S_REQ);
  assign bmem_addr  = bmem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imem_line_responder                                        |
// | Purpose  : Directed scoreboard bench for imem_line_responder.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_imem_line_responder;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  imem_line_responder #(.NUM_SETS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          handshakes = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] baddr_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: responses and burst handshakes are checked against the queues.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && imem_resp === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp actual=%h expected=none", imem_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", imem_rdata, e);
        end
      end
      if (mon_en && bmem_read === 1'b1 && bmem_ready === 1'b1) begin
        handshakes++;
        if (baddr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bmem_req actual=%h expected=none", bmem_addr);
        end else begin
          e = baddr_q.pop_front();
          chk("bmem_addr", bmem_addr, e);
        end
      end
    end
  end

  task automatic wait_bmem_read();
    int n = 0;
    while (bmem_read !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bmem_read !== 1'b1) begin
      total++; bad++;
      $display("FAIL bmem_read_timeout actual=0 expected=1");
    end
  endtask

  task automatic send_beat(input logic [63:0] b);
    bmem_rvalid = 1'b1;
    bmem_rdata  = b;
    step();
    bmem_rvalid = 1'b0;
    bmem_rdata  = 64'h0;
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [3:0] m, input logic [31:0] exp,
                         input int rdly, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3);
    exp_q.push_back(exp);
    baddr_q.push_back({a[31:5], 5'b0});
    imem_addr  = a;
    imem_rmask = m;
    step();
    imem_rmask = 4'h0;
    imem_addr  = 32'hdeadbeef;
    wait_bmem_read();
    repeat (rdly) step();
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    send_beat(b0);
    send_beat(b1);
    send_beat(b2);
    send_beat(b3);
    step();
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [3:0] m, input logic [31:0] exp);
    exp_q.push_back(exp);
    imem_addr  = a;
    imem_rmask = m;
    step();
    imem_rmask = 4'h0;
    imem_addr  = 32'hdeadbeef;
    step();
  endtask

  localparam logic [63:0] B0 = 64'h11111111_00000013;
  localparam logic [63:0] B1 = 64'h22222222_00000093;
  localparam logic [63:0] B2 = 64'h33333333_00000113;
  localparam logic [63:0] B3 = 64'h44444444_00000193;

  initial begin
    rst         = 1'b1;
    imem_addr   = 32'h0;
    imem_rmask  = 4'h0;
    bmem_ready  = 1'b0;
    bmem_rdata  = 64'h0;
    bmem_rvalid = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("rst_resp",      {31'h0, imem_resp}, 32'h0);
    chk("rst_rdata",     imem_rdata,         32'h0);
    chk("rst_bmem_read", {31'h0, bmem_read}, 32'h0);
    chk("rst_bmem_addr", bmem_addr,          32'h0);
    mon_en = 1'b1;

    // 1: cold miss, fill, word 0
    do_miss(32'h1eceb000, 4'hF, 32'h00000013, 2, B0, B1, B2, B3);
    chk("t1_handshakes", handshakes, 1);

    // 2: back-to-back hits
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h44444444);
    imem_addr = 32'h1eceb004; imem_rmask = 4'hF;
    step();
    imem_addr = 32'h1eceb01C; imem_rmask = 4'hF;
    step();
    imem_rmask = 4'h0;
    step();
    chk("t2_handshakes", handshakes, 1);

    // 3: conflict miss in set 0, then eviction of the first line
    do_miss(32'h1eceb200, 4'hF, 32'h55555555, 0,
            64'haaaaaaaa_55555555, 64'hbbbbbbbb_66666666,
            64'hcccccccc_77777777, 64'hdddddddd_88888888);
    do_miss(32'h1eceb010, 4'hF, 32'h00000113, 1, B0, B1, B2, B3);
    chk("t3_handshakes", handshakes, 3);

    // 4: unaligned address with narrow mask returns the full word
    do_hit(32'h1eceb006, 4'b0001, 32'h11111111);
    do_hit(32'h1eceb018, 4'b1000, 32'h00000193);

    // 5: reset during fill discards the partial line
    baddr_q.push_back(32'h1eceb040);
    imem_addr = 32'h1eceb040; imem_rmask = 4'hF;
    step();
    imem_rmask = 4'h0;
    wait_bmem_read();
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    send_beat(64'h0badf00d_cafef00d);
    send_beat(64'h12121212_34343434);
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_beat(64'h56565656_78787878);
    send_beat(64'h9a9a9a9a_bcbcbcbc);
    repeat (2) step();
    chk("t5_bmem_read_low", {31'h0, bmem_read}, 32'h0);
    do_miss(32'h1eceb040, 4'hF, 32'hcafef00d, 0,
            64'h0badf00d_cafef00d, 64'h12121212_34343434,
            64'h56565656_78787878, 64'h9a9a9a9a_bcbcbcbc);
    chk("t5_handshakes", handshakes, 5);

    // 6: long REQ wait with toggling request lines
    exp_q.push_back(32'h03030303);
    baddr_q.push_back(32'h1eceb080);
    imem_addr = 32'h1eceb08C; imem_rmask = 4'hF;
    step();
    imem_rmask = 4'h0;
    wait_bmem_read();
    for (int i = 0; i < 10; i++) begin
      imem_rmask = (i % 2 == 0) ? 4'hF : 4'h0;
      imem_addr  = 32'h1eceb000 + 32'(i * 4);
      chk("t6_bmem_read", {31'h0, bmem_read}, 32'h1);
      chk("t6_bmem_addr", bmem_addr, 32'h1eceb080);
      step();
    end
    imem_rmask = 4'h0;
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    send_beat(64'h01010101_02020202);
    send_beat(64'h03030303_04040404);
    send_beat(64'h05050505_06060606);
    send_beat(64'h07070707_08080808);
    repeat (3) step();
    chk("t6_handshakes", handshakes, 6);
    chk("rdata_hold", imem_rdata, 32'h03030303);

    chk("exp_q_empty",   exp_q.size(),   0);
    chk("baddr_q_empty", baddr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
